kbd_event_sequencer: RTL

Bus master that sequences the PS/2 KeyboardController through its register port: it polls STATUS, fetches each scan code and decodes set-2 prefixes (E0/F0/E1). It tracks modifier state and queues complete key events in a small FIFO. The 65C02 reads decoded events from its own register window instead of touching the raw keyboard controller.

---
 rtl/kbd_event_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/kbd_event_sequencer.sv
// rtl/kbd_event_sequencer.sv - polls the PS/2 keyboard controller, decodes set-2 prefixes
// and modifiers, and queues complete key events for CPU readout.
module kbd_event_sequencer #(
   parameter int POLL_GAP = 4,
   parameter int FIFO_AW  = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   output logic       kbd_en_o,
   output logic [7:0] kbd_addr_o,
   input  logic [7:0] kbd_din_i,
   input  logic       en_i,
   input  logic [7:0] addr_i,
   output logic [7:0] dout_o
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
   localparam int CNT_W = FIFO_AW + 1;

   typedef enum logic [2:0] {
      IDLE, POLL_REQ, POLL_WAIT, READ_REQ, READ_WAIT, DECODE
   } state_t;

   state_t             state_q, state_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               kbd_en_q, kbd_en_d;
   logic [7:0]         kbd_addr_q, kbd_addr_d;
   logic [7:0]         code_q, code_d;
   logic               ext_q, ext_d, brk_q, brk_d;
   logic               lshift_q, lshift_d, rshift_q, rshift_d;
   logic               lctrl_q, lctrl_d, rctrl_q, rctrl_d, caps_q, caps_d;
   logic [15:0]        mem_q [DEPTH], mem_d [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               ovf_q, ovf_d;
   logic               flags_sel_q, flags_sel_d;
   logic [7:0]         dout_q, dout_d;

   logic               push;
   logic [7:0]         ev_flags;
   logic [15:0]        head;
   logic               empty, full, flags_sel, pop, push_ok;

   // Sequencer and set-2 decoder.
   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      kbd_en_d   = 1'b0;
      kbd_addr_d = kbd_addr_q;
      code_d     = code_q;
      ext_d      = ext_q;
      brk_d      = brk_q;
      lshift_d   = lshift_q;
      rshift_d   = rshift_q;
      lctrl_d    = lctrl_q;
      rctrl_d    = rctrl_q;
      caps_d     = caps_q;
      push       = 1'b0;
      ev_flags   = 8'h00;
      case (state_q)
         IDLE: begin
            if (gap_q == GAP_W'(POLL_GAP)) begin
               gap_d      = '0;
               state_d    = POLL_REQ;
               kbd_en_d   = 1'b1;
               kbd_addr_d = 8'h00;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         POLL_REQ: state_d = POLL_WAIT;
         POLL_WAIT: begin
            if (kbd_din_i[0]) begin
               state_d    = READ_REQ;
               kbd_en_d   = 1'b1;
               kbd_addr_d = 8'h01;
            end else begin
               state_d = IDLE;
            end
         end
         READ_REQ: state_d = READ_WAIT;
         READ_WAIT: begin
            code_d  = kbd_din_i;
            state_d = DECODE;
         end
         DECODE: begin
            state_d = IDLE;
            case (code_q)
               8'hF0: brk_d = 1'b1;
               8'hE0: ext_d = 1'b1;
               8'hE1: ;
               8'h00, 8'hFF: begin
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
               default: begin
                  if (code_q == 8'h12) lshift_d = ~brk_q;
                  if (code_q == 8'h59) rshift_d = ~brk_q;
                  if (code_q == 8'h14) begin
                     if (ext_q) rctrl_d = ~brk_q;
                     else       lctrl_d = ~brk_q;
                  end
                  // Caps lock latches on make only; its break code is ignored.
                  if (code_q == 8'h58 && !ext_q && !brk_q) caps_d = ~caps_q;
                  ev_flags = {3'b000, ext_q, caps_d, lctrl_d | rctrl_d,
                              lshift_d | rshift_d, brk_q};
                  push  = 1'b1;
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   // Event FIFO and CPU register window.
   always_comb begin
      head      = mem_q[rd_ptr_q];
      empty     = (count_q == '0);
      full      = (count_q == CNT_W'(DEPTH));
      flags_sel = en_i && (addr_i == 8'h02);
      pop       = flags_sel && !flags_sel_q && !empty;
      push_ok   = push && (!full || pop);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = {code_q, ev_flags};
         wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
      // A drop in the same cycle as the STATUS read must survive the clear.
      ovf_d = ovf_q;
      if (en_i && addr_i == 8'h00) ovf_d = 1'b0;
      if (push && full && !pop)    ovf_d = 1'b1;
      flags_sel_d = flags_sel;
      dout_d      = dout_q;
      if (en_i) begin
         case (addr_i)
            8'h00:   dout_d = {5'b00000, ovf_q, full, !empty};
            8'h01:   dout_d = empty ? 8'h00 : head[15:8];
            8'h02:   dout_d = empty ? 8'h00 : head[7:0];
            8'h03:   dout_d = {3'b000, rctrl_q, lctrl_q, rshift_q, lshift_q, caps_q};
            default: dout_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         gap_q       <= '0;
         kbd_en_q    <= 1'b0;
         kbd_addr_q  <= 8'h00;
         code_q      <= 8'h00;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         lshift_q    <= 1'b0;
         rshift_q    <= 1'b0;
         lctrl_q     <= 1'b0;
         rctrl_q     <= 1'b0;
         caps_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         flags_sel_q <= 1'b0;
         dout_q      <= 8'h00;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         kbd_en_q    <= kbd_en_d;
         kbd_addr_q  <= kbd_addr_d;
         code_q      <= code_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         lshift_q    <= lshift_d;
         rshift_q    <= rshift_d;
         lctrl_q     <= lctrl_d;
         rctrl_q     <= rctrl_d;
         caps_q      <= caps_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         flags_sel_q <= flags_sel_d;
         dout_q      <= dout_d;
      end
   end

   assign kbd_en_o   = kbd_en_q;
   assign kbd_addr_o = kbd_addr_q;
   assign dout_o     = dout_q;

endmodule
